data_ram_slave: RTL and testbench

//  Memory-side responder for the MEM stage's data-memory request interface (ce/we/addr/sel/data).

---
 rtl/data_ram_slave.sv | 152 +++++++++++++++
 tb/tb_data_ram_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_slave.sv
// data_ram_slave: word-organised big-endian data RAM behind the MEM-stage
// request interface. A request is captured in IDLE, held for WAIT_CYCLES
// wait states, then executed on the edge entering ACK, which produces a
// one-cycle ack_o pulse together with read data or an out-of-range error.
module data_ram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stallreq_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Captured request; byte offset bits are irrelevant for a word RAM.
    logic        we_q;
    logic [29:0] waddr_q;
    logic [3:0]  sel_q;
    logic [31:0] wdata_q;

    logic [31:0] data_q;
    logic        ack_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    // Effective request: live inputs when the access fires straight out of
    // IDLE (WAIT_CYCLES=0), otherwise the fields captured on entry to WAIT.
    logic        req_we;
    logic [29:0] req_waddr;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic [ADDR_W-1:0] req_idx;
    logic        req_oor;
    logic        go_access;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // Select between live and captured request fields and decode the range.
    always_comb begin
        if (state_q == S_IDLE) begin
            req_we    = we_i;
            req_waddr = addr_i[31:2];
            req_sel   = sel_i;
            req_wdata = data_i;
        end else begin
            req_we    = we_q;
            req_waddr = waddr_q;
            req_sel   = sel_q;
            req_wdata = wdata_q;
        end
        req_idx = req_waddr[ADDR_W-1:0];
        req_oor = |req_waddr[29:ADDR_W];
    end

    // Next-state and wait-counter logic; ce_i low during WAIT aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ce_i) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ce_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // The access happens on the very edge that enters ACK; reset wins.
        go_access = !rst && (state_d == S_ACK) && (state_q != S_ACK);
    end

    // FSM state, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= go_access;
            err_q   <= go_access && req_oor;
            if (go_access && !req_we && !req_oor) begin
                data_q <= mem[req_idx];
            end else begin
                data_q <= 32'd0;
            end
            if (state_q == S_IDLE && ce_i) begin
                we_q    <= we_i;
                waddr_q <= addr_i[31:2];
                sel_q   <= sel_i;
                wdata_q <= data_i;
            end
        end
    end

    // Byte-lane masked write; sel[3] is the big-endian byte 0 (bits 31:24).
    always_ff @(posedge clk) begin
        if (go_access && req_we && !req_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_o     = data_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign stallreq_o = !rst && ce_i && !ack_q;

endmodule

// File: tb/tb_data_ram_slave.sv
// Directed bench for data_ram_slave: one instance with two wait states and
// one with none, sharing clock, reset and request fields but not ce.
module tb_data_ram_slave;

    logic        clk;
    logic        rst;
    logic        ce0, ce1;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] dout0, dout1;
    logic        ack0, ack1, err0, err1, stall0, stall1;

    int total = 0;
    int bad   = 0;

    data_ram_slave #(.ADDR_W(10), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we), .addr_i(addr),
        .sel_i(sel), .data_i(wdat), .data_o(dout0), .ack_o(ack0),
        .err_o(err0), .stallreq_o(stall0)
    );

    data_ram_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we), .addr_i(addr),
        .sel_i(sel), .data_i(wdat), .data_o(dout1), .ack_o(ack1),
        .err_o(err1), .stallreq_o(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ack_of(input int u);
        return (u == 0) ? ack0 : ack1;
    endfunction

    function automatic logic stall_of(input int u);
        return (u == 0) ? stall0 : stall1;
    endfunction

    function automatic logic err_of(input int u);
        return (u == 0) ? err0 : err1;
    endfunction

    function automatic logic [31:0] dout_of(input int u);
        return (u == 0) ? dout0 : dout1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request on instance u; lat counts stalled cycles before ack.
    task automatic access(input int u, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d, input bit scr,
                          input int exp_lat, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        int lat;
        bit got;
        @(posedge clk); #1;
        we = w; addr = a; sel = s; wdat = d;
        if (u == 0) ce0 = 1'b1; else ce1 = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack_of(u)) begin
                got = 1'b1;
            end else begin
                if (stall_of(u)) lat++;
                if (scr && i == 1) begin
                    addr = 32'h20; wdat = 32'h0; sel = 4'hF;
                end
            end
        end
        chk({tag, "_ack"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stall_at_ack"}, 32'(stall_of(u)), 32'd0);
        chk({tag, "_data"}, dout_of(u), exp_rd);
        chk({tag, "_err"}, 32'(err_of(u)), 32'(exp_err));
        ce0 = 1'b0;
        ce1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce0 = 1'b1; ce1 = 1'b1; we = 1'b0;
        addr = 32'h0; sel = 4'hF; wdat = 32'h0;

        // Reset with ce held high: stall must be forced low.
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_stall0", 32'(stall0), 32'd0);
        chk("rst_stall1", 32'(stall1), 32'd0);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_data0", dout0, 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        ce0 = 1'b0; ce1 = 1'b0; rst = 1'b0;

        // Full-word write then read, two wait states.
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 3, 32'h0, 1'b0, "wr10");
        access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0, "rd10");

        // Single-lane write via byte address 0x11, sel=0100.
        access(0, 1'b1, 32'h11, 4'b0100, 32'hAAAAAAAA, 1'b0, 3, 32'h0, 1'b0, "wrb11");
        access(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 3, 32'hDEAABEEF, 1'b0, "rdb10");

        // No lanes enabled: acked, memory unchanged.
        access(0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 3, 32'h0, 1'b0, "wrsel0");
        access(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 3, 32'hDEAABEEF, 1'b0, "rdsel0");

        // Out of range write and read must not alias onto word 0.
        access(0, 1'b1, 32'h0, 4'hF, 32'h11111111, 1'b0, 3, 32'h0, 1'b0, "wr00");
        access(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b0, 3, 32'h0, 1'b1, "wroor");
        access(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, 3, 32'h0, 1'b1, "rdoor");
        access(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 3, 32'h11111111, 1'b0, "rd00");

        // Inputs changed after capture are ignored.
        access(0, 1'b1, 32'h20, 4'hF, 32'h22222222, 1'b0, 3, 32'h0, 1'b0, "wr20");
        access(0, 1'b1, 32'h28, 4'hF, 32'h33333333, 1'b1, 3, 32'h0, 1'b0, "wrscr");
        access(0, 1'b0, 32'h28, 4'hF, 32'h0, 1'b0, 3, 32'h33333333, 1'b0, "rd28");
        access(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 3, 32'h22222222, 1'b0, "rd20a");

        // Abort: ce dropped before the edge that would enter ACK.
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h20; sel = 4'hF; wdat = 32'h99999999; ce0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_stall", 32'(stall0), 32'd1);
        ce0 = 1'b0;
        @(negedge clk);
        chk("abort_ack_a", 32'(ack0), 32'd0);
        @(negedge clk);
        chk("abort_ack_b", 32'(ack0), 32'd0);
        access(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 3, 32'h22222222, 1'b0, "rd20b");

        // Zero wait states: single ack latency, then back-to-back reads.
        access(1, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1'b0, 1, 32'h0, 1'b0, "z_wr0");
        access(1, 1'b1, 32'h4, 4'hF, 32'h0B0B0B0B, 1'b0, 1, 32'h0, 1'b0, "z_wr4");
        @(posedge clk); #1;
        we = 1'b0; addr = 32'h0; sel = 4'hF; ce1 = 1'b1;
        @(negedge clk);
        chk("b2b_ack1", 32'(ack1), 32'd0);
        @(negedge clk);
        chk("b2b_ack2", 32'(ack1), 32'd1);
        chk("b2b_data2", dout1, 32'hA0A0A0A0);
        addr = 32'h4;
        @(negedge clk);
        chk("b2b_ack3", 32'(ack1), 32'd0);
        chk("b2b_data3", dout1, 32'h0);
        @(negedge clk);
        chk("b2b_ack4", 32'(ack1), 32'd1);
        chk("b2b_data4", dout1, 32'h0B0B0B0B);
        ce1 = 1'b0;

        // Reset in the middle of a pending write discards it.
        access(0, 1'b1, 32'h24, 4'hF, 32'h44444444, 1'b0, 3, 32'h0, 1'b0, "wr24");
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h24; sel = 4'hF; wdat = 32'h55555555; ce0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", 32'(ack0), 32'd0);
        chk("mid_rst_data", dout0, 32'd0);
        chk("mid_rst_stall", 32'(stall0), 32'd0);
        rst = 1'b0;
        ce0 = 1'b0;
        access(0, 1'b0, 32'h24, 4'hF, 32'h0, 1'b0, 3, 32'h44444444, 1'b0, "rd24");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
